// File: rtl/seq_pkg.sv
// seq_pkg: shared FSM encoding and serial-pattern constants for pattern generators and detectors
package seq_pkg;
  localparam int SEQ_MAX_LEN = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2, DONE = 2'd3} state_t;
  localparam logic [2:0] PAT_101 = 3'b101;
  localparam int PAT_101_LEN = 3;
endpackage

// File: rtl/seq_shreg.sv
// seq_shreg: loadable left shift register whose MSB is the next pattern bit, reloadable per frame
module seq_shreg #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               restart,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] data,
  input  logic [LEN_W-1:0]   len,
  output logic               head
);
  logic [MAX_LEN-1:0] saved, sr, aligned;
  assign aligned = data << (LEN_W'(MAX_LEN) - len);
  // head is the bit emitted this edge, so load/restart bypass the register
  assign head = load ? aligned[MAX_LEN-1] : restart ? saved[MAX_LEN-1] : sr[MAX_LEN-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      saved <= '0;
      sr <= '0;
    end else if (load) begin
      saved <= aligned;
      sr <= aligned << 1;
    end else if (restart) sr <= saved << 1;
    else if (shift) sr <= sr << 1;
  end
endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: MSB-first serial pattern transmitter with repeats, idle gaps, busy and done
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int MAX_LEN = SEQ_MAX_LEN,
  parameter int LEN_W = $clog2(MAX_LEN + 1),
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [CNT_W-1:0]   repeat_cnt,
  input  logic [GAP_W-1:0]   gap,
  input  logic               idle_level,
  output logic               ser_out,
  output logic               ser_valid,
  output logic               frame_start,
  output logic               busy,
  output logic               done
);
  state_t state, state_nx;
  logic [LEN_W-1:0] left, left_nx, len_q, len_c;
  logic [CNT_W-1:0] frames, frames_nx;
  logic [GAP_W-1:0] gcnt, gcnt_nx, gap_q;
  logic idle_q, cap, load, restart, shift, head;
  logic out_nx, valid_nx, fs_nx;

  seq_shreg #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_shreg (
    .clk(clk), .reset(reset), .load(load), .restart(restart), .shift(shift),
    .data(pattern), .len(len_c), .head(head)
  );

  always_comb begin
    len_c = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
    cap = (state == IDLE) && start;
    state_nx = state;
    left_nx = left;
    frames_nx = frames;
    gcnt_nx = gcnt;
    load = 1'b0;
    restart = 1'b0;
    shift = 1'b0;
    valid_nx = 1'b0;
    fs_nx = 1'b0;
    case (state)
      IDLE: if (start) begin
        if (len_c == '0 || repeat_cnt == '0) state_nx = DONE;
        else begin
          state_nx = SHIFT;
          load = 1'b1;
          valid_nx = 1'b1;
          fs_nx = 1'b1;
          left_nx = len_c - 1'b1;
          frames_nx = repeat_cnt;
        end
      end
      SHIFT: if (left != '0) begin
        shift = 1'b1;
        valid_nx = 1'b1;
        left_nx = left - 1'b1;
      end else begin
        frames_nx = frames - 1'b1;
        if (frames_nx == '0) state_nx = DONE;
        else if (gap_q != '0) begin
          state_nx = GAP;
          gcnt_nx = gap_q - 1'b1;
        end else begin
          restart = 1'b1;
          valid_nx = 1'b1;
          fs_nx = 1'b1;
          left_nx = len_q - 1'b1;
        end
      end
      GAP: if (gcnt != '0) gcnt_nx = gcnt - 1'b1;
      else begin
        state_nx = SHIFT;
        restart = 1'b1;
        valid_nx = 1'b1;
        fs_nx = 1'b1;
        left_nx = len_q - 1'b1;
      end
      DONE: state_nx = IDLE;
    endcase
    out_nx = valid_nx ? head : cap ? idle_level : idle_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      left <= '0;
      frames <= '0;
      gcnt <= '0;
      len_q <= '0;
      gap_q <= '0;
      idle_q <= 1'b0;
      ser_out <= 1'b0;
      ser_valid <= 1'b0;
      frame_start <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      left <= left_nx;
      frames <= frames_nx;
      gcnt <= gcnt_nx;
      if (cap) begin
        len_q <= len_c;
        gap_q <= gap;
        idle_q <= idle_level;
      end
      ser_out <= out_nx;
      ser_valid <= valid_nx;
      frame_start <= fs_nx;
      busy <= state_nx != IDLE;
      done <= state_nx == DONE;
    end
  end
endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed checks of seq_pattern_gen with per-cycle traces against hand-derived vectors
module tb_seq_pattern_gen;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, idle_level = 1'b0;
  logic [15:0] pattern = '0;
  logic [4:0] length = '0;
  logic [7:0] repeat_cnt = '0;
  logic [3:0] gap = '0;
  logic ser_out, ser_valid, frame_start, busy, done;
  logic [31:0] so_v, sv_v, fs_v, bz_v, dn_v;
  int checks = 0, failures = 0;

  seq_pattern_gen dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .length(length),
    .repeat_cnt(repeat_cnt), .gap(gap), .idle_level(idle_level), .ser_out(ser_out),
    .ser_valid(ser_valid), .frame_start(frame_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Start strobe at edge N; returns #1 into cycle N+1.
  task automatic start_job(input logic [15:0] p, input logic [4:0] l, input logic [7:0] r,
                           input logic [3:0] g, input logic il);
    pattern = p; length = l; repeat_cnt = r; gap = g; idle_level = il; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Records n cycles, earliest cycle ending up as the leftmost bit; smask[i] pulses start during cycle i.
  task automatic capture(input int n, input logic [31:0] smask);
    so_v = '0; sv_v = '0; fs_v = '0; bz_v = '0; dn_v = '0;
    for (int i = 1; i <= n; i++) begin
      so_v = {so_v[30:0], ser_out};
      sv_v = {sv_v[30:0], ser_valid};
      fs_v = {fs_v[30:0], frame_start};
      bz_v = {bz_v[30:0], busy};
      dn_v = {dn_v[30:0], done};
      if (i < n) begin
        start = smask[i];
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({ser_out, ser_valid, frame_start, busy, done} !== 5'b0) begin failures++; $display("FAIL reset outs got=%b exp=00000", {ser_out, ser_valid, frame_start, busy, done}); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    start_job(16'h0005, 5'd3, 8'd1, 4'd0, 1'b0);
    capture(6, 0);
    checks++; if (so_v !== 32'b101000) begin failures++; $display("FAIL single ser_out got=%b exp=101000", so_v); end
    checks++; if (sv_v !== 32'b111000) begin failures++; $display("FAIL single ser_valid got=%b exp=111000", sv_v); end
    checks++; if (fs_v !== 32'b100000) begin failures++; $display("FAIL single frame_start got=%b exp=100000", fs_v); end
    checks++; if (bz_v !== 32'b111100) begin failures++; $display("FAIL single busy got=%b exp=111100", bz_v); end
    checks++; if (dn_v !== 32'b000100) begin failures++; $display("FAIL single done got=%b exp=000100", dn_v); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] w;
    logic [7:0] hits;
    int nbits;
    start_job(16'h0005, 5'd3, 8'd2, 4'd0, 1'b0);
    capture(8, 0);
    checks++; if (so_v !== 32'b10110100) begin failures++; $display("FAIL b2b ser_out got=%b exp=10110100", so_v); end
    checks++; if (sv_v !== 32'b11111100) begin failures++; $display("FAIL b2b ser_valid got=%b exp=11111100", sv_v); end
    checks++; if (fs_v !== 32'b10010000) begin failures++; $display("FAIL b2b frame_start got=%b exp=10010000", fs_v); end
    checks++; if (bz_v !== 32'b11111110) begin failures++; $display("FAIL b2b busy got=%b exp=11111110", bz_v); end
    checks++; if (dn_v !== 32'b00000010) begin failures++; $display("FAIL b2b done got=%b exp=00000010", dn_v); end
    // Overlapping 101 detector over the valid bits; hit bit k set when serial position k+1 completes 101.
    w = '0; hits = '0; nbits = 0;
    for (int i = 7; i >= 0; i--) if (sv_v[i]) begin
      w = {w[1:0], so_v[i]};
      nbits++;
      if (nbits >= 3 && w == 3'b101) hits[nbits-1] = 1'b1;
    end
    checks++; if (hits !== 8'b00100100) begin failures++; $display("FAIL b2b det101 hits got=%b exp=00100100", hits); end
  endtask

  task automatic test_gap;
    start_job(16'h0005, 5'd3, 8'd3, 4'd2, 1'b1);
    capture(15, 0);
    checks++; if (so_v !== 32'b101111011110111) begin failures++; $display("FAIL gap ser_out got=%b exp=101111011110111", so_v); end
    checks++; if (sv_v !== 32'b111001110011100) begin failures++; $display("FAIL gap ser_valid got=%b exp=111001110011100", sv_v); end
    checks++; if (fs_v !== 32'b100001000010000) begin failures++; $display("FAIL gap frame_start got=%b exp=100001000010000", fs_v); end
    checks++; if (bz_v !== 32'b111111111111110) begin failures++; $display("FAIL gap busy got=%b exp=111111111111110", bz_v); end
    checks++; if (dn_v !== 32'b000000000000010) begin failures++; $display("FAIL gap done got=%b exp=000000000000010", dn_v); end
  endtask

  task automatic test_degenerate;
    start_job(16'h0005, 5'd0, 8'd5, 4'd0, 1'b0);
    capture(3, 0);
    checks++; if (sv_v !== 32'b000) begin failures++; $display("FAIL deg_len0 ser_valid got=%b exp=000", sv_v); end
    checks++; if (bz_v !== 32'b100) begin failures++; $display("FAIL deg_len0 busy got=%b exp=100", bz_v); end
    checks++; if (dn_v !== 32'b100) begin failures++; $display("FAIL deg_len0 done got=%b exp=100", dn_v); end
    start_job(16'h0005, 5'd3, 8'd0, 4'd0, 1'b1);
    capture(3, 0);
    checks++; if (so_v !== 32'b111) begin failures++; $display("FAIL deg_rep0 ser_out got=%b exp=111", so_v); end
    checks++; if ({sv_v[2:0], fs_v[2:0]} !== 6'b0) begin failures++; $display("FAIL deg_rep0 valid/fs got=%b exp=000000", {sv_v[2:0], fs_v[2:0]}); end
    checks++; if (bz_v !== 32'b100) begin failures++; $display("FAIL deg_rep0 busy got=%b exp=100", bz_v); end
    checks++; if (dn_v !== 32'b100) begin failures++; $display("FAIL deg_rep0 done got=%b exp=100", dn_v); end
  endtask

  task automatic test_start_busy;
    start_job(16'h0005, 5'd3, 8'd2, 4'd0, 1'b0);
    pattern = 16'hFFFF; length = 5'd16; repeat_cnt = 8'd3; gap = 4'd1; idle_level = 1'b1;
    capture(8, 32'h84);
    checks++; if (so_v !== 32'b10110100) begin failures++; $display("FAIL busy_start ser_out got=%b exp=10110100", so_v); end
    checks++; if (sv_v !== 32'b11111100) begin failures++; $display("FAIL busy_start ser_valid got=%b exp=11111100", sv_v); end
    checks++; if (bz_v !== 32'b11111110) begin failures++; $display("FAIL busy_start busy got=%b exp=11111110", bz_v); end
    checks++; if (dn_v !== 32'b00000010) begin failures++; $display("FAIL busy_start done got=%b exp=00000010", dn_v); end
  endtask

  task automatic test_full_width;
    start_job(16'hA5C3, 5'd16, 8'd1, 4'd0, 1'b0);
    capture(18, 0);
    checks++; if (so_v !== 32'b101001011100001100) begin failures++; $display("FAIL full ser_out got=%b exp=101001011100001100", so_v); end
    checks++; if (sv_v !== 32'b111111111111111100) begin failures++; $display("FAIL full ser_valid got=%b exp=111111111111111100", sv_v); end
    checks++; if (fs_v !== 32'b100000000000000000) begin failures++; $display("FAIL full frame_start got=%b exp=100000000000000000", fs_v); end
    checks++; if (bz_v !== 32'b111111111111111110) begin failures++; $display("FAIL full busy got=%b exp=111111111111111110", bz_v); end
    checks++; if (dn_v !== 32'b000000000000000010) begin failures++; $display("FAIL full done got=%b exp=000000000000000010", dn_v); end
    start_job(16'hA5C3, 5'd31, 8'd1, 4'd0, 1'b0);
    capture(18, 0);
    checks++; if (so_v !== 32'b101001011100001100) begin failures++; $display("FAIL clamp ser_out got=%b exp=101001011100001100", so_v); end
    checks++; if (dn_v !== 32'b000000000000000010) begin failures++; $display("FAIL clamp done got=%b exp=000000000000000010", dn_v); end
  endtask

  task automatic test_reset_mid;
    start_job(16'h0007, 5'd3, 8'd3, 4'd0, 1'b1);
    capture(5, 0);
    checks++; if ({ser_out, ser_valid} !== 2'b11) begin failures++; $display("FAIL midjob pre-reset got=%b exp=11", {ser_out, ser_valid}); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if ({ser_out, ser_valid, frame_start, busy, done} !== 5'b0) begin failures++; $display("FAIL midjob reset outs got=%b exp=00000", {ser_out, ser_valid, frame_start, busy, done}); end
    capture(6, 0);
    checks++; if ({so_v[5:0], sv_v[5:0], bz_v[5:0], dn_v[5:0]} !== 24'b0) begin failures++; $display("FAIL midjob after-reset so/sv/bz/dn got=%b exp=0", {so_v[5:0], sv_v[5:0], bz_v[5:0], dn_v[5:0]}); end
    start_job(16'h0005, 5'd3, 8'd1, 4'd0, 1'b0);
    capture(6, 0);
    checks++; if (so_v !== 32'b101000) begin failures++; $display("FAIL midjob restart ser_out got=%b exp=101000", so_v); end
    checks++; if (dn_v !== 32'b000100) begin failures++; $display("FAIL midjob restart done got=%b exp=000100", dn_v); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_gap;
    test_degenerate;
    test_start_busy;
    test_full_width;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_pattern_gen.md
Name: seq_pattern_gen

Overview:
Serial bit-pattern transmitter, the stimulus side for the team's serial sequence detectors. It loads a pattern word, length, repeat count and inter-frame gap on a start strobe. It then emits the pattern MSB-first, one bit per clock, with a valid qualifier and optional idle gaps between repetitions. It reports busy and a done pulse, so a bench or system controller can chain jobs.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (width of pattern port)
LEN_W, $clog2(MAX_LEN+1), width of length port (default 5)
CNT_W, 8, width of repeat counter
GAP_W, 4, width of inter-frame gap counter

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high; forces all state and outputs to reset values at next edge
start  in  1  job request; sampled only when busy==0
pattern  in  MAX_LEN  bits to send; bit length-1 is sent first, bit 0 last
length  in  LEN_W  number of pattern bits per frame, 0..MAX_LEN; values >MAX_LEN clamp to MAX_LEN
repeat_cnt  in  CNT_W  number of frames to send; 0 = send nothing
gap  in  GAP_W  idle cycles inserted between consecutive frames (not after last)
idle_level  in  1  value driven on ser_out when not sending
ser_out  out  1  serial data, registered
ser_valid  out  1  high on cycles where ser_out carries a pattern bit, registered
frame_start  out  1  one-cycle pulse coincident with first bit of each frame
busy  out  1  high from cycle after accepted start through the DONE cycle
done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset values: ser_out=0, ser_valid=0, frame_start=0, busy=0, done=0, state=IDLE, all counters and captured registers 0.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE: start=1 at edge N captures pattern, clamped length, repeat_cnt, gap and idle_level.
  - length==0 or repeat_cnt==0 -> DONE; ser_valid stays 0.
  - otherwise -> SHIFT; first bit (pattern[length-1]) on ser_out with ser_valid=1 and frame_start=1 in cycle N+1.
- SHIFT: one bit per cycle, descending index to bit 0; ser_valid=1 throughout.
  - After bit 0, decrement frames remaining.
  - If frames remain and gap>0 -> GAP.
  - If frames remain and gap==0 -> next frame's first bit on the very next cycle (back-to-back, frame_start=1).
  - If no frames remain -> DONE.
- GAP: exactly gap cycles with ser_valid=0 and ser_out=captured idle_level, then SHIFT with frame_start=1.
- DONE: one cycle; done=1, busy=1, ser_valid=0, ser_out=idle_level; then IDLE.
- IDLE/GAP/DONE: ser_out=captured idle_level (0 after reset until first job).
- start while busy==0 is accepted; start while busy==1 (including the DONE cycle) is ignored and not queued.
- Timing for a job of L bits, R frames, G gap:
  - total busy cycles = R*L + (R-1)*G + 1;
  - done asserted at cycle N + R*L + (R-1)*G + 1.
- reset mid-job: outputs return to reset values at the next edge; no done pulse; job discarded.
- Input ports other than start are don't-care after capture; changing them mid-job has no effect.
- Counters saturate-free: bit index LEN_W bits, frame counter CNT_W bits, gap counter GAP_W bits; no wrap is reachable given the clamp rules.

Decomposition:
- Shared package seq_pkg: state encoding localparams (IDLE, SHIFT, GAP, DONE, 2-bit), default MAX_LEN, and the shared serial-pattern constants used by the detectors, e.g. the 3-bit pattern 101.
- One natural sub-module, seq_shreg: loadable MAX_LEN-bit left shift register with length-aligned MSB output. The FSM, counters and output registers remain in seq_pattern_gen.

Test Plan:
- Single frame: pattern=0x0005, length=3, repeat=1, gap=0, start at N -> ser_out 1,0,1 with ser_valid=1 at N+1..N+3, frame_start at N+1, done at N+4, busy N+1..N+4.
- Back-to-back frames: pattern 101, repeat=2, gap=0 -> ser_out 1,0,1,1,0,1 contiguous, frame_start at N+1 and N+4, done at N+7.
  - Fed into the 101 detector, det asserts after the bits at positions 3 and 6; no third hit, because the boundary pair 1,1 does not form 101.
- Gapped frames: pattern 101, repeat=3, gap=2, idle_level=1 -> frames at N+1..3, N+6..8, N+11..13; ser_valid=0 and ser_out=1 at N+4,5,9,10; done at N+14.
- Degenerate jobs:
  - length=0, repeat=5 -> ser_valid never high, done at N+1, busy only N+1.
  - length=3, repeat=0 -> same response.
- Start while busy: start pulsed at N+2 and in the DONE cycle of a running job -> both ignored; output sequence and done timing unchanged.
- Full-width and reset: length=16, pattern=0xA5C3, repeat=1 -> 16 bits MSB-first.
  - Separate run: assert reset at N+5 mid-frame -> next cycle all outputs 0, no done pulse, and a new start is then accepted normally.
